puf_resp_tx: RTL and testbench
==============================

Name: puf_resp_tx

Overview:
- Framer/serializer downstream of the RO-PUF core and response validator.
- On a start pulse it captures the 256-bit PUF response and the validator's verdict, then streams a byte frame to the SPI master.
- Uses the SPI master's one-byte TX handshake: tx_dv out, tx_ready in.
- The top-level FSM only pulses start and watches busy/done.

Parameters:
- RESP_W, 256: response width in bits; must be a multiple of 8.
- HDR_BYTE, 8'hA5: first byte of every frame.
- NBYTES, RESP_W/8: response byte count; derived, not overridden.

Ports:
- clk  input  1  system clock (the divided PUF/SPI clock).
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; captures response and res_valid.
- response  input  RESP_W  PUF response word; sampled only on accepted start.
- res_valid  input  1  validator verdict; sampled with response.
- tx_ready  input  1  SPI master idle/ready (o_TX_Ready).
- tx_dv  output  1  one-cycle byte strobe to SPI master (i_TX_DV).
- tx_byte  output  8  byte to send (i_TX_Byte); held stable until the next strobe.
- busy  output  1  high from accepted start until frame end.
- done  output  1  one-cycle pulse after the last byte is accepted.
- dropped  output  1  one-cycle pulse when start arrives while busy.

Behaviour:
- One clock and a synchronous active-high reset, as decided.
- Reset values: tx_dv=0, tx_byte=0, busy=0, done=0, dropped=0. Internal state: state=IDLE, idx=0, chk=0, shadow register=0.
- Frame: HDR_BYTE, then STATUS = {7'b0, res_valid}, then NBYTES response bytes MSB-first (response[RESP_W-1 -: 8] first), then CHK.
  - CHK is the XOR of all preceding frame bytes.
  - Total NBYTES+3 = 35 bytes at default.
- FSM states: IDLE, LOAD, STROBE, WAIT_LO, WAIT_HI, FIN.
  - IDLE: start=1 → capture response and res_valid into shadow, busy=1, idx=0, chk=0, go to LOAD.
  - LOAD: tx_byte <= frame byte[idx]; chk <= chk ^ that byte; go to STROBE.
  - STROBE: tx_dv=1 only when tx_ready=1, then go to WAIT_LO. Otherwise stay in STROBE with tx_dv=0.
  - WAIT_LO: wait for tx_ready=0, with a 4-cycle timeout. On timeout proceed as if it dropped; this guards against a master that turns around ready instantly. Then go to WAIT_HI.
  - WAIT_HI: wait for tx_ready=1. Then, if idx==NBYTES+2, go to FIN; else idx++ and go to LOAD.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- The CHK byte is the chk value accumulated over the previous bytes; it is not XORed into itself.
- tx_dv is never high for two consecutive cycles.
- Minimum spacing between strobes is 4 cycles.
- start while busy (any state other than IDLE, including FIN): ignored, dropped=1 for that cycle, shadow unchanged.
- start in the same cycle as reset: reset wins; no capture, no dropped.
- Reset mid-frame: return to IDLE next edge with tx_dv=0 and busy=0; no done pulse. The partial frame is abandoned; the SPI master is responsible for its own byte.
- start in the cycle after FIN (state IDLE): accepted normally.
- tx_ready stuck low: the block waits indefinitely in STROBE or WAIT_HI. No timeout there; this is the top level's responsibility.
- response/res_valid may change freely after capture without affecting the frame.
- idx width is clog2(NBYTES+3).

Test Plan:
- response=256'h0102...1F20 (byte k = k+1), res_valid=1, model ready drops 1 cycle after strobe and rises 16 cycles later.
  - Bytes A5, 01, 01..20, then CHK = A5^01^(XOR 01..20).
  - 35 tx_dv pulses, done once, busy low after.
- response all-zero, res_valid=0 → frame A5, 00, 32×00, A5. tx_byte is stable between strobes.
- start pulsed at byte 10 of an active frame → dropped=1 for one cycle, frame bytes identical to the undisturbed run, a single done.
- reset asserted after the 5th tx_dv → next cycle tx_dv=0, busy=0, no done.
  - A new start then yields a full correct 35-byte frame beginning A5.
- tx_ready held low 50 cycles at frame start → no tx_dv during that time; the first strobe comes the cycle after ready rises.
- Ready model that never drops → WAIT_LO timeout after 4 cycles. Frame still completes with exactly 35 strobes, each ≥4 cycles apart.

Source files
------------

// File: rtl/puf_resp_tx_if.sv
// Byte-wide TX handshake between the PUF response framer and the SPI master.
// The framer drives tx_dv/tx_byte; the SPI master answers with tx_ready.
interface puf_resp_tx_if;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_ready;

  modport master (
    output tx_dv,
    output tx_byte,
    input  tx_ready
  );

  modport slave (
    input  tx_dv,
    input  tx_byte,
    output tx_ready
  );
endinterface

// File: rtl/puf_resp_tx.sv
// PUF response framer: header, status, response bytes MSB-first, XOR check.
// Streams one byte per SPI master handshake.
module puf_resp_tx #(
  parameter int         RESP_W   = 256,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RESP_W-1:0] response,
  input  logic              res_valid,
  puf_resp_tx_if.master     spi,
  output logic              busy,
  output logic              done,
  output logic              dropped
);

  localparam int NBYTES = RESP_W / 8;
  localparam int IDX_W  = $clog2(NBYTES + 3);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES + 2);
  localparam logic [IDX_W-1:0] STAT = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT_LO,
    WAIT_HI,
    FIN
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        chk;
  logic [RESP_W-1:0] shadow;
  logic              vld_q;
  logic [1:0]        tmo;
  logic [7:0]        frame_byte;

  // Response bytes come from the top of a shifting copy of the capture.
  always_comb begin
    frame_byte = shadow[RESP_W-1 -: 8];
    unique case (1'b1)
      idx == '0:   frame_byte = HDR_BYTE;
      idx == STAT: frame_byte = {7'b0, vld_q};
      idx == LAST: frame_byte = chk;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      chk         <= '0;
      shadow      <= '0;
      vld_q       <= 1'b0;
      tmo         <= '0;
      spi.tx_dv   <= 1'b0;
      spi.tx_byte <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      spi.tx_dv <= 1'b0;
      done      <= 1'b0;
      dropped   <= start && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (start) begin
            shadow <= response;
            vld_q  <= res_valid;
            busy   <= 1'b1;
            idx    <= '0;
            chk    <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          spi.tx_byte <= frame_byte;
          chk         <= chk ^ frame_byte;
          if (idx > STAT && idx != LAST)
            shadow <= {shadow[RESP_W-9:0], 8'h00};
          state <= STROBE;
        end
        STROBE: begin
          if (spi.tx_ready) begin
            spi.tx_dv <= 1'b1;
            tmo       <= '0;
            state     <= WAIT_LO;
          end
        end
        // A master that never drops ready is let through after 4 cycles.
        WAIT_LO: begin
          if (!spi.tx_ready || tmo == 2'd3)
            state <= WAIT_HI;
          else
            tmo <= tmo + 2'd1;
        end
        WAIT_HI: begin
          if (spi.tx_ready) begin
            if (idx == LAST) begin
              state <= FIN;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= LOAD;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_tx.sv
// Scoreboard bench for puf_resp_tx: random frames against a byte-list model,
// with a behavioural SPI master that drops and restores ready.
module tb_puf_resp_tx;
  localparam int RW = 256;
  localparam int NB = RW / 8;
  localparam int FL = NB + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [RW-1:0] response;
  logic          res_valid;
  logic          busy, done, dropped;

  logic rdy = 1'b1;
  logic hold_low = 1'b0;
  logic no_drop = 1'b0;
  int   rise_dly = 16;

  puf_resp_tx_if spi();
  assign spi.tx_ready = rdy && !hold_low;

  puf_resp_tx #(.RESP_W(RW), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .response(response), .res_valid(res_valid),
    .spi(spi), .busy(busy), .done(done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int exp_done = 0, got_done = 0;
  int exp_drop = 0, got_drop = 0;
  int frame_strobes = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit have_last = 0;
  logic prev_dv = 1'b0;
  logic [7:0] last_sent = 8'h00;
  logic [7:0] q[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: frame is a byte list; check byte is the XOR of everything before it.
  task automatic push_frame(input logic [RW-1:0] r, input logic v);
    logic [7:0] b, x;
    x = 8'hA5; q.push_back(8'hA5);
    b = {7'b0, v}; x ^= b; q.push_back(b);
    for (int k = 0; k < NB; k++) begin
      b = r[RW-1-8*k -: 8];
      x ^= b;
      q.push_back(b);
    end
    q.push_back(x);
  endtask

  function automatic logic [RW-1:0] rand_resp();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model: ready falls after a seen strobe, returns rise_dly later.
  initial begin
    forever begin
      @(negedge clk);
      if (spi.tx_dv && !no_drop) begin
        @(posedge clk);
        #1 rdy = 1'b0;
        repeat (rise_dly) @(posedge clk);
        #1 rdy = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (spi.tx_dv) begin
        frame_strobes++;
        check("dv_back_to_back", {31'b0, prev_dv}, 0);
        if (have_last)
          check("strobe_spacing_ge4", (cyc - last_cyc >= 4) ? 1 : 0, 1);
        have_last = 1;
        last_cyc  = cyc;
        if (q.size() == 0) begin
          check("unexpected_strobe_byte", {24'b0, spi.tx_byte}, 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", {24'b0, spi.tx_byte}, {24'b0, q.pop_front()});
        end
        last_sent = spi.tx_byte;
      end else if (busy && q.size() > 0) begin
        compared++;
        if (spi.tx_byte !== last_sent && spi.tx_byte !== q[0]) begin
          mismatched++;
          $display("FAIL tx_byte_stable: got %0h expected %0h or %0h",
                   spi.tx_byte, last_sent, q[0]);
        end
      end
      if (done) begin
        got_done++;
        check("done_frame_len", frame_strobes, FL);
        check("done_queue_empty", q.size(), 0);
        check("done_busy_low", {31'b0, busy}, 0);
        frame_strobes = 0;
      end
      if (dropped) got_drop++;
      prev_dv = spi.tx_dv;
    end
  end

  task automatic start_frame(input logic [RW-1:0] r, input logic v);
    response  = r;
    res_valid = v;
    start     = 1'b1;
    push_frame(r, v);
    exp_done++;
    tick();
    start     = 1'b0;
    response  = rand_resp();
    res_valid = ~v;
    check("busy_after_start", {31'b0, busy}, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic wait_strobes(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (frame_strobes >= n) return;
      tick();
    end
    check("strobe_wait_timeout", frame_strobes, n);
  endtask

  initial begin
    logic [RW-1:0] r;
    reset = 1'b1; start = 1'b0; response = '0; res_valid = 1'b0;
    repeat (3) tick();
    check("rst_tx_dv", {31'b0, spi.tx_dv}, 0);
    check("rst_tx_byte", {24'b0, spi.tx_byte}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_dropped", {31'b0, dropped}, 0);
    reset = 1'b0;
    tick();

    // Counting pattern, byte k = k+1
    for (int k = 0; k < NB; k++) r[RW-1-8*k -: 8] = 8'(k + 1);
    start_frame(r, 1'b1);
    wait_done();

    // Start in the cycle right after FIN: all-zero, invalid
    start_frame('0, 1'b0);
    wait_done();

    // Start while busy is dropped
    start_frame(rand_resp(), 1'($urandom));
    wait_strobes(10);
    response = rand_resp();
    start = 1'b1;
    exp_drop++;
    tick();
    start = 1'b0;
    wait_done();

    // Reset after the 5th strobe, together with a start
    start_frame(rand_resp(), 1'b1);
    wait_strobes(5);
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("abort_tx_dv", {31'b0, spi.tx_dv}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_dropped", {31'b0, dropped}, 0);
    check("abort_tx_byte", {24'b0, spi.tx_byte}, 0);
    reset = 1'b0;
    start = 1'b0;
    q.delete();
    exp_done--;
    frame_strobes = 0;
    last_sent = 8'h00;
    have_last = 0;
    repeat (5) tick();
    check("abort_no_busy", {31'b0, busy}, 0);
    start_frame(rand_resp(), 1'b0);
    wait_done();

    // Ready held low at frame start
    hold_low = 1'b1;
    start_frame(rand_resp(), 1'b1);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("hold_no_strobe", {31'b0, spi.tx_dv}, 0);
    end
    hold_low = 1'b0;
    tick();
    check("first_strobe_after_ready", {31'b0, spi.tx_dv}, 1);
    wait_done();

    // Ready never drops: WAIT_LO timeout path
    no_drop = 1'b1;
    repeat (2) begin
      start_frame(rand_resp(), 1'($urandom));
      wait_done();
    end
    no_drop = 1'b0;

    // Random ready turnaround delays
    repeat (3) begin
      rise_dly = $urandom_range(1, 20);
      start_frame(rand_resp(), 1'($urandom));
      wait_done();
    end

    repeat (5) tick();
    check("done_count", got_done, exp_done);
    check("dropped_count", got_drop, exp_drop);
    check("queue_drained", q.size(), 0);
    check("idle_busy", {31'b0, busy}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
